// File: rtl/vp_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vp_pkg
//  Brief    : Precision-mode encodings, lane geometry and FSM state type shared
//             by the variable-precision result serializer.
//  Revision : 1.0 - initial release
// ============================================================================
package vp_pkg;

  localparam logic [1:0] MODE_4B  = 2'b00;
  localparam logic [1:0] MODE_8B  = 2'b01;
  localparam logic [1:0] MODE_16B = 2'b10;
  localparam logic [1:0] MODE_INV = 2'b11;

  localparam int unsigned c_entry_w     = 66;
  localparam int unsigned c_lane_stride = 16;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } ser_state_e;

  function automatic logic [2:0] lane_count(input logic [1:0] mode);
    case (mode)
      MODE_4B:  lane_count = 3'd4;
      MODE_8B:  lane_count = 3'd2;
      MODE_16B: lane_count = 3'd1;
      default:  lane_count = 3'd0;
    endcase
  endfunction

  function automatic logic [5:0] lane_width(input logic [1:0] mode);
    case (mode)
      MODE_4B:  lane_width = 6'd8;
      MODE_8B:  lane_width = 6'd16;
      MODE_16B: lane_width = 6'd32;
      default:  lane_width = 6'd0;
    endcase
  endfunction

  // Narrow lanes sit on a 16-bit stride regardless of their width.
  function automatic logic [5:0] lane_offset(input logic [1:0] idx);
    lane_offset = {idx, 4'b0000};
  endfunction

  function automatic logic [31:0] lane_extract(input logic [63:0] data,
                                               input logic [1:0]  mode,
                                               input logic [1:0]  idx);
    logic [31:0] shifted;
    logic [31:0] mask;
    shifted      = 32'(data >> lane_offset(idx));
    // A 32-bit shift by 32 wraps to zero, so the 32-bit lane mask becomes all ones.
    mask         = (32'd1 << lane_width(mode)) - 32'd1;
    lane_extract = shifted & mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vp_result_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : vp_result_fifo
//  Brief    : Synchronous FIFO holding {mode, result} entries; head is read
//             straight from the storage registers.
//  Revision : 1.0 - initial release
// ============================================================================
module vp_result_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 66
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned c_ptr_w = $clog2(DEPTH);
  localparam logic [c_ptr_w:0] c_full_count = {1'b1, {c_ptr_w{1'b0}}};

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_ptr_w:0]   r_count;
  logic               w_push_ok;
  logic               w_pop_ok;

  // A push into a full FIFO is dropped even if a pop frees a slot this cycle.
  assign w_push_ok = push && (r_count != c_full_count);
  assign w_pop_ok  = pop && (r_count != '0);

  assign full  = (r_count == c_full_count);
  assign empty = (r_count == '0);
  assign count = r_count;
  assign head  = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/vp_result_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : vp_result_serializer
//  Brief    : Buffers packed multiply results and emits one zero-extended
//             sub-product per handshake with lane index and last flag.
//  Revision : 1.0 - initial release
// ============================================================================
module vp_result_serializer
  import vp_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [63:0] result,
  input  logic [1:0]  mode,
  output logic        in_full,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [1:0]  out_lane,
  output logic        out_last,
  output logic [1:0]  out_mode,
  output logic        overflow,
  output logic        err_mode
);

  localparam int unsigned c_cnt_w = $clog2(FIFO_DEPTH) + 1;
  localparam logic [c_cnt_w-1:0] c_full_count = {1'b1, {(c_cnt_w-1){1'b0}}};

  logic [c_entry_w-1:0] w_fifo_head;
  logic                 w_fifo_full;
  logic                 w_fifo_empty;
  logic [c_cnt_w-1:0]   w_fifo_count;
  logic                 w_fifo_pop;
  logic [1:0]           w_head_mode;
  logic [63:0]          w_head_data;

  ser_state_e  r_state;
  ser_state_e  w_state_nx;
  logic [63:0] r_hold_data;
  logic [63:0] w_hold_data_nx;
  logic [1:0]  r_hold_mode;
  logic [1:0]  w_hold_mode_nx;
  logic [1:0]  r_idx;
  logic [1:0]  w_idx_nx;
  logic        w_err_nx;

  logic        w_valid_nx;
  logic [31:0] w_data_nx;
  logic [1:0]  w_lane_nx;
  logic        w_last_nx;
  logic [1:0]  w_mode_nx;

  vp_result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (c_entry_w)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (valid_in),
    .pop   (w_fifo_pop),
    .wdata ({mode, result}),
    .head  (w_fifo_head),
    .full  (w_fifo_full),
    .empty (w_fifo_empty),
    .count (w_fifo_count)
  );

  assign w_head_mode = w_fifo_head[65:64];
  assign w_head_data = w_fifo_head[63:0];
  assign in_full     = (w_fifo_count == c_full_count);

  always_comb begin
    w_state_nx     = r_state;
    w_hold_data_nx = r_hold_data;
    w_hold_mode_nx = r_hold_mode;
    w_idx_nx       = r_idx;
    w_fifo_pop     = 1'b0;
    w_err_nx       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (!w_fifo_empty) begin
          w_fifo_pop = 1'b1;
          if (w_head_mode == MODE_INV) begin
            w_err_nx = 1'b1;
          end else begin
            w_hold_data_nx = w_head_data;
            w_hold_mode_nx = w_head_mode;
            w_idx_nx       = 2'd0;
            w_state_nx     = ST_EMIT;
          end
        end
      end
      ST_EMIT: begin
        if (out_ready) begin
          if (!out_last) begin
            w_idx_nx = r_idx + 2'd1;
          end else if (!w_fifo_empty && (w_head_mode != MODE_INV)) begin
            // Chain straight into the next word so there is no bubble.
            w_fifo_pop     = 1'b1;
            w_hold_data_nx = w_head_data;
            w_hold_mode_nx = w_head_mode;
            w_idx_nx       = 2'd0;
          end else begin
            w_state_nx = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase
  end

  // Output values are computed from the next-cycle holding state and then registered.
  always_comb begin
    w_valid_nx = (w_state_nx == ST_EMIT);
    w_data_nx  = 32'd0;
    w_lane_nx  = 2'd0;
    w_last_nx  = 1'b0;
    w_mode_nx  = 2'd0;
    if (w_valid_nx) begin
      w_data_nx = lane_extract(w_hold_data_nx, w_hold_mode_nx, w_idx_nx);
      w_lane_nx = w_idx_nx;
      w_last_nx = ({1'b0, w_idx_nx} == (lane_count(w_hold_mode_nx) - 3'd1));
      w_mode_nx = w_hold_mode_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_hold_data <= 64'd0;
      r_hold_mode <= 2'd0;
      r_idx       <= 2'd0;
      out_valid   <= 1'b0;
      out_data    <= 32'd0;
      out_lane    <= 2'd0;
      out_last    <= 1'b0;
      out_mode    <= 2'd0;
      overflow    <= 1'b0;
      err_mode    <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_hold_data <= w_hold_data_nx;
      r_hold_mode <= w_hold_mode_nx;
      r_idx       <= w_idx_nx;
      out_valid   <= w_valid_nx;
      out_data    <= w_data_nx;
      out_lane    <= w_lane_nx;
      out_last    <= w_last_nx;
      out_mode    <= w_mode_nx;
      err_mode    <= w_err_nx;
      if (valid_in && w_fifo_full) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vp_result_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vp_result_serializer
//  Brief    : Scoreboard bench for vp_result_serializer with directed vectors.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vp_result_serializer;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_in = 1'b0;
  logic [63:0] result = 64'd0;
  logic [1:0]  mode = 2'd0;
  logic        out_ready = 1'b0;
  logic        in_full;
  logic        out_valid;
  logic [31:0] out_data;
  logic [1:0]  out_lane;
  logic        out_last;
  logic [1:0]  out_mode;
  logic        overflow;
  logic        err_mode;

  always #5 clk = ~clk;

  vp_result_serializer #(.FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .result    (result),
    .mode      (mode),
    .in_full   (in_full),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_lane  (out_lane),
    .out_last  (out_last),
    .out_mode  (out_mode),
    .overflow  (overflow),
    .err_mode  (err_mode)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  lane;
    logic        last;
    logic [1:0]  mode;
  } beat_t;

  beat_t sb[$];
  beat_t mon_e;
  beat_t mon_g;
  int    total = 0;
  int    bad = 0;
  int    hs_count = 0;
  int    err_count = 0;
  int    hs_mark = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_beat(input logic [31:0] d, input logic [1:0] l,
                             input logic la, input logic [1:0] m);
    beat_t b;
    b.data = d;
    b.lane = l;
    b.last = la;
    b.mode = m;
    sb.push_back(b);
  endtask

  task automatic push_word(input logic [1:0] m, input logic [63:0] r);
    mode     = m;
    result   = r;
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 50; i++) begin
      if (out_valid) return;
      tick();
    end
    total++;
    bad++;
    $display("FAIL %s: out_valid never rose, required 1 within 50 cycles", name);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0) break;
      tick();
    end
    chk(name, sb.size(), 0);
    repeat (5) tick();
  endtask

  // Monitor: every accepted beat must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      hs_count++;
      total++;
      mon_g = {out_data, out_lane, out_last, out_mode};
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL beat_unexpected: got data=%h lane=%0d last=%0d mode=%0d, required no beat",
                 out_data, out_lane, out_last, out_mode);
      end else begin
        mon_e = sb.pop_front();
        if (mon_g !== mon_e) begin
          bad++;
          $display("FAIL beat: got data=%h lane=%0d last=%0d mode=%0d, required data=%h lane=%0d last=%0d mode=%0d",
                   mon_g.data, mon_g.lane, mon_g.last, mon_g.mode,
                   mon_e.data, mon_e.lane, mon_e.last, mon_e.mode);
        end
      end
    end
    if (err_mode) err_count++;
  end

  initial begin
    tick();
    tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data",  out_data, 0);
    chk("rst_out_lane",  out_lane, 0);
    chk("rst_out_last",  out_last, 0);
    chk("rst_out_mode",  out_mode, 0);
    chk("rst_overflow",  overflow, 0);
    chk("rst_err_mode",  err_mode, 0);
    chk("rst_in_full",   in_full, 0);
    rst = 1'b0;
    tick();

    // Four 8-bit lanes, last flag only on lane 3, one-cycle pop latency.
    out_ready = 1'b1;
    expect_beat(32'h04, 2'd0, 1'b0, 2'b00);
    expect_beat(32'h10, 2'd1, 1'b0, 2'b00);
    expect_beat(32'h31, 2'd2, 1'b0, 2'b00);
    expect_beat(32'hE1, 2'd3, 1'b1, 2'b00);
    push_word(2'b00, 64'h00E1_0031_0010_0004);
    chk("latency_e0_valid", out_valid, 0);
    tick();
    chk("latency_e1_valid", out_valid, 1);
    chk("latency_e1_data", out_data, 32'h04);
    wait_drain("t1_drained");

    // Mode 01 followed by mode 10 with no bubble between words.
    expect_beat(32'h0000_0C40, 2'd0, 1'b0, 2'b01);
    expect_beat(32'h0000_1E61, 2'd1, 1'b1, 2'b01);
    expect_beat(32'h0FFE_0001, 2'd0, 1'b1, 2'b10);
    push_word(2'b01, 64'h0000_0000_1E61_0C40);
    push_word(2'b10, 64'h0000_0000_0FFE_0001);
    chk("nobubble_c0", out_valid, 1);
    tick();
    chk("nobubble_c1", out_valid, 1);
    tick();
    chk("nobubble_c2", out_valid, 1);
    chk("nobubble_c2_mode", out_mode, 2'b10);
    tick();
    chk("nobubble_idle", out_valid, 0);
    wait_drain("t2_drained");

    // Stall mid-word for 5 cycles; lane 1 must hold and then resume.
    out_ready = 1'b0;
    expect_beat(32'h11, 2'd0, 1'b0, 2'b00);
    expect_beat(32'h22, 2'd1, 1'b0, 2'b00);
    expect_beat(32'h33, 2'd2, 1'b0, 2'b00);
    expect_beat(32'h44, 2'd3, 1'b1, 2'b00);
    push_word(2'b00, 64'h0044_0033_0022_0011);
    wait_valid("t3_valid");
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_data",  out_data, 32'h22);
      chk("stall_lane",  out_lane, 1);
      chk("stall_last",  out_last, 0);
      tick();
    end
    out_ready = 1'b1;
    wait_drain("t3_drained");

    // Overflow: DEPTH+2 words with no ready; the last one is dropped.
    out_ready = 1'b0;
    chk("pre_overflow", overflow, 0);
    for (int k = 1; k <= DEPTH + 1; k++) begin
      expect_beat(32'h1000 + 32'(k), 2'd0, 1'b1, 2'b10);
    end
    for (int k = 1; k <= DEPTH + 2; k++) begin
      push_word(2'b10, {32'hDEAD_BEEF, 32'h1000 + 32'(k)});
    end
    chk("ovf_in_full", in_full, 1);
    chk("ovf_flag", overflow, 1);
    out_ready = 1'b1;
    wait_drain("t4_drained");
    chk("ovf_sticky", overflow, 1);
    chk("ovf_in_full_clear", in_full, 0);

    // Invalid-mode word between two valid words.
    err_count = 0;
    hs_mark = hs_count;
    expect_beat(32'hAAAA_0001, 2'd0, 1'b1, 2'b10);
    expect_beat(32'hBBBB_0002, 2'd0, 1'b1, 2'b10);
    push_word(2'b10, 64'h0000_0000_AAAA_0001);
    push_word(2'b11, 64'h1234_5678_9ABC_DEF0);
    push_word(2'b10, 64'h0000_0000_BBBB_0002);
    wait_drain("t5_drained");
    chk("err_pulses", err_count, 1);
    chk("inv_beats", hs_count - hs_mark, 2);

    // Reset while lane 2 of a mode 00 word is pending, with a word queued.
    out_ready = 1'b0;
    expect_beat(32'hA0, 2'd0, 1'b0, 2'b00);
    expect_beat(32'hB0, 2'd1, 1'b0, 2'b00);
    push_word(2'b00, 64'h00D0_00C0_00B0_00A0);
    push_word(2'b10, 64'h0000_0000_0000_0055);
    wait_valid("t6_valid");
    out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
    chk("pre_rst_lane", out_lane, 2);
    chk("pre_rst_sb", sb.size(), 0);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data",  out_data, 0);
    chk("mid_rst_lane",  out_lane, 0);
    chk("mid_rst_last",  out_last, 0);
    chk("mid_rst_mode",  out_mode, 0);
    chk("mid_rst_ovf",   overflow, 0);
    chk("mid_rst_full",  in_full, 0);
    hs_mark = hs_count;
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (20) tick();
    chk("post_rst_beats", hs_count - hs_mark, 0);
    chk("post_rst_valid", out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
